if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage. It is the producer of the pc/inst pair that the decode stage consumes.
//  Owns the PC and issues word fetches over a req/ack instruction-memory port.
//  Buffers returned words in a small prefetch FIFO and drives the registered IF/ID outputs.
//  Honours stall (hold) and flush/redirect (branch, exception) from pipeline control.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              prefetch entries {pc,inst}; power of 2, >=2
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   reset, synchronous, active-high
//  imem_req_o    out  1   fetch request valid
//  imem_addr_o   out  32  fetch word address (bits[1:0]=0)
//  imem_ack_i    in   1   request accepted; imem_rdata_i valid same cycle
//  imem_rdata_i  in   32  instruction word
//  stall_i       in   1   decode not accepting; hold IF/ID outputs
//  flush_i       in   1   discard all in-flight/buffered work, redirect
//  flush_pc_i    in   32  redirect target, valid with flush_i
//  id_pc_o       out  32  IF/ID pc to decode
//  id_inst_o     out  32  IF/ID instruction to decode (0 = NOP when invalid)
//  id_valid_o    out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Priority at each edge: rst > flush_i > stall_i > normal.
//  Reset values:
//   - fetch_pc=RESET_PC, FIFO empty
//   - imem_req_o=0, imem_addr_o=RESET_PC
//   - id_pc_o=0, id_inst_o=0, id_valid_o=0
//  Fetch handshake:
//   - imem_addr_o=fetch_pc
//   - imem_req_o=1 when !rst, !flush_i and (fifo_count + fifo_push_pending) < FIFO_DEPTH
//   - transfer = imem_req_o & imem_ack_i; on transfer fetch_pc += 4 (wraps mod 2^32)
//   - addr held stable while req=1 and ack=0; only flush may change it
//  Transfer routing (same edge as ack):
//   - FIFO empty, !stall_i: word loads IF/ID directly; 1-cycle ack-to-id_valid_o latency
//   - otherwise: {pc,inst} pushed to FIFO tail
//  IF/ID update when !stall_i:
//   - loads FIFO head (pop) if non-empty, else bypass word, else bubble
//   - bubble: id_valid_o=0, id_inst_o=0, id_pc_o keeps last value
//  stall_i=1:
//   - id_* hold; no pop; fetch continues until FIFO full, then req drops
//  FIFO full:
//   - no push possible (req already low)
//   - pop frees a slot; req re-asserts the next cycle
//  flush_i=1:
//   - FIFO cleared; any same-cycle ack data discarded (fetch_pc not incremented)
//   - fetch_pc<=flush_pc_i; id_valid_o<=0, id_inst_o<=0
//   - imem_req_o=0 during the flush cycle; first redirected request the cycle after
//  rst mid-operation:
//   - state reinitialised next edge; pending ack ignored (req=0 under rst)
//  Ordering: instructions reach decode in strict fetch order, no duplicates, no gaps except bubbles.
// STRUCTURE
//  Shared defines file: `InstAddrBus, `InstBus, `ZeroWord, `RstEnable, `NOPInst.
//  Add FetchFifoDepth default there.
//  Sub-module fetch_fifo: sync FIFO {pc,inst}; ports push/pop/clear/full/empty/count;
//   wrap-around ptrs with extra MSB.
//  Top holds PC, request logic, bypass mux, IF/ID register.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> req=0, id_valid_o=0, id_inst_o=0;
//     first req after release addr=0x0.
//  2. Zero-wait stream: ack every cycle, words 0x34010001,0x34220002,0x34430003
//     -> id_pc_o 0x0,0x4,0x8 on consecutive cycles, id_valid_o=1.
//  3. Stall 4 cycles mid-stream: id_* frozen; FIFO reaches 2, req drops;
//     release -> buffered pcs emerge in order, no gap, then fetch resumes.
//  4. Wait states: ack 3 cycles after req -> addr stable 3 cycles;
//     id_valid_o=0 bubbles, no duplicate pc.
//  5. Flush to 0x100 with same-cycle ack of 0x8 -> 0x8 never reaches decode;
//     next req addr 0x100; id_valid_o=0 that edge.
//  6. flush_i with stall_i, FIFO full -> flush wins, FIFO empty;
//     then rst mid-stream -> restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, constants and the prefetch entry type
package if_fetch_unit_pkg;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// if_fetch_unit_fetch_fifo: sync FIFO of {pc,inst}, wrap-around pointers with extra MSB
module if_fetch_unit_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign dout = mem[rp[AW-1:0]];
  // pointer update; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, imem request, prefetch bypass and IF/ID register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] fetch_pc;
  logic xfer, bypass, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t head;
  if_fetch_unit_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush_i),
    .push(push),
    .pop(pop),
    .din('{pc: fetch_pc, inst: imem_rdata_i}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign imem_addr_o = fetch_pc;
  // request only while a slot is free; a word goes straight to IF/ID when nothing is queued ahead of it
  always_comb begin
    imem_req_o = !rst && !flush_i && (count < CW'(FIFO_DEPTH));
    xfer = imem_req_o && imem_ack_i;
    bypass = xfer && empty && !stall_i;
    push = xfer && !bypass && !full;
    pop = !flush_i && !stall_i && !empty;
  end
  // PC and IF/ID register: rst > flush > stall > normal
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      id_pc_o <= ZERO_WORD;
      id_inst_o <= NOP_INST;
      id_valid_o <= 1'b0;
    end else if (flush_i) begin
      fetch_pc <= flush_pc_i;
      id_inst_o <= NOP_INST;
      id_valid_o <= 1'b0;
    end else begin
      if (xfer) fetch_pc <= fetch_pc + 32'd4;
      if (!stall_i) begin
        id_pc_o <= !empty ? head.pc : bypass ? fetch_pc : id_pc_o;
        id_inst_o <= !empty ? head.inst : bypass ? imem_rdata_i : NOP_INST;
        id_valid_o <= !empty || bypass;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, stall, wait states, flush and reset
module tb_if_fetch_unit;
  logic clk = 0, rst = 1, ack = 0, stall = 0, flush = 0;
  logic [31:0] flush_pc = 0;
  logic req, valid;
  logic [31:0] addr, rdata, id_pc, id_inst;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'h3401_0001 : a == 32'h4 ? 32'h3422_0002 :
           a == 32'h8 ? 32'h3443_0003 : 32'h3400_0000 | a;
  endfunction
  assign rdata = word(addr);
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .stall_i(stall),
    .flush_i(flush), .flush_pc_i(flush_pc), .id_pc_o(id_pc),
    .id_inst_o(id_inst), .id_valid_o(valid)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_inst"}, id_inst, inst);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
  endtask
  initial begin
    tick();
    tick();
    chk("rst_req", {31'b0, req}, 0);
    chk_id("rst", 0, 0, 0);
    rst = 0;
    #1;
    chk("first_req", {31'b0, req}, 1);
    chk("first_addr", addr, 0);
    ack = 1;
    tick();
    chk_id("s0", 32'h0, 32'h3401_0001, 1);
    tick();
    chk_id("s1", 32'h4, 32'h3422_0002, 1);
    tick();
    chk_id("s2", 32'h8, 32'h3443_0003, 1);
    stall = 1;
    tick();
    tick();
    chk("stall_req_drop", {31'b0, req}, 0);
    tick();
    tick();
    chk_id("stall_hold", 32'h8, 32'h3443_0003, 1);
    chk("stall_addr", addr, 32'h14);
    stall = 0;
    tick();
    chk_id("rel0", 32'hC, 32'h3400_000C, 1);
    chk("rel_req", {31'b0, req}, 1);
    tick();
    chk("rel1_pc", id_pc, 32'h10);
    tick();
    chk("rel2_pc", id_pc, 32'h14);
    tick();
    chk_id("rel3", 32'h18, 32'h3400_0018, 1);
    ack = 0;
    tick();
    chk_id("drain", 32'h1C, 32'h3400_001C, 1);
    chk("ws_addr0", addr, 32'h20);
    tick();
    chk_id("ws_bub0", 32'h1C, 0, 0);
    chk("ws_addr1", addr, 32'h20);
    tick();
    chk_id("ws_bub1", 32'h1C, 0, 0);
    chk("ws_addr2", addr, 32'h20);
    chk("ws_req", {31'b0, req}, 1);
    ack = 1;
    tick();
    chk_id("ws_word", 32'h20, 32'h3400_0020, 1);
    ack = 0;
    tick();
    chk_id("ws_nodup", 32'h20, 0, 0);
    flush = 1;
    flush_pc = 32'h100;
    ack = 1;
    #1;
    chk("flush_req", {31'b0, req}, 0);
    tick();
    flush = 0;
    ack = 0;
    #1;
    chk_id("flush_bub", 32'h20, 0, 0);
    chk("flush_addr", addr, 32'h100);
    chk("flush_req_after", {31'b0, req}, 1);
    ack = 1;
    tick();
    chk_id("redir", 32'h100, 32'h3400_0100, 1);
    stall = 1;
    tick();
    tick();
    chk("full_req", {31'b0, req}, 0);
    chk_id("full_hold", 32'h100, 32'h3400_0100, 1);
    flush = 1;
    flush_pc = 32'h200;
    tick();
    flush = 0;
    stall = 0;
    #1;
    chk("fs_valid", {31'b0, valid}, 0);
    chk("fs_req", {31'b0, req}, 1);
    chk("fs_addr", addr, 32'h200);
    tick();
    chk_id("fs_word", 32'h200, 32'h3400_0200, 1);
    tick();
    chk("fs_next", id_pc, 32'h204);
    rst = 1;
    #1;
    chk("mrst_req", {31'b0, req}, 0);
    tick();
    rst = 0;
    #1;
    chk_id("mrst", 0, 0, 0);
    chk("mrst_addr", addr, 0);
    chk("mrst_req_after", {31'b0, req}, 1);
    tick();
    chk_id("mrst_word", 32'h0, 32'h3401_0001, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
